// File: rtl/rename_free_list_ctrl.sv
// Physical-register free list for the 2-wide rename stage: speculative head for
// allocation, committed head for flush recovery, tail for releases from commit.
module rename_free_list_ctrl #(
    parameter int unsigned NUM_ARCH = 32,
    parameter int unsigned NUM_PREG = 64,
    parameter int unsigned TAG_W    = 6
) (
    input  logic                                     Clk,
    input  logic                                     Rst,
    input  logic                                     Flush,
    input  logic                                     Stall,
    input  logic [1:0]                               Alloc_Req,
    output logic                                     Alloc_Grant,
    output logic [TAG_W-1:0]                         Alloc_Tag0,
    output logic [TAG_W-1:0]                         Alloc_Tag1,
    output logic                                     Alloc_Stall,
    input  logic [1:0]                               Cmt_Alloc,
    input  logic [1:0]                               Rel_Valid,
    input  logic [TAG_W-1:0]                         Rel_Tag0,
    input  logic [TAG_W-1:0]                         Rel_Tag1,
    output logic [$clog2(NUM_PREG-NUM_ARCH):0]       Free_Cnt,
    output logic                                     Err
);

    localparam int unsigned DEPTH = NUM_PREG - NUM_ARCH;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [TAG_W-1:0] entry [DEPTH];
    logic [PTR_W-1:0] h, c, t;
    logic             err_q;

    logic [1:0]       n;
    logic [PTR_W-1:0] free_cnt;
    logic [PTR_W-1:0] h_p1;
    logic             grant;
    logic [PTR_W-1:0] h_adv;
    logic [1:0]       cmt;
    logic             cmt_illegal;
    logic             cmt_over;
    logic [PTR_W-1:0] c_next;
    logic [PTR_W-1:0] h_next;
    logic             rel0_ok, rel1_ok, rel_drop;
    logic [PTR_W-1:0] t1, t_next;

    assign n        = {1'b0, Alloc_Req[0]} + {1'b0, Alloc_Req[1]};
    assign free_cnt = t - h;
    assign h_p1     = h + PTR_W'(1);
    assign Free_Cnt = free_cnt;
    assign Err      = err_q;

    // All-or-nothing grant; flush dominates both grant and stall request
    always_comb begin
        grant       = 1'b0;
        Alloc_Grant = 1'b0;
        Alloc_Stall = 1'b0;
        Alloc_Tag0  = '0;
        Alloc_Tag1  = '0;
        if (!Rst) begin
            grant       = (n != 2'd0) && !Stall && !Flush && (free_cnt >= PTR_W'(n));
            Alloc_Grant = grant;
            Alloc_Stall = (n != 2'd0) && (free_cnt < PTR_W'(n)) && !Flush;
            if (Alloc_Req[0]) begin
                Alloc_Tag0 = entry[h[IDX_W-1:0]];
                Alloc_Tag1 = entry[h_p1[IDX_W-1:0]];
            end else begin
                Alloc_Tag0 = entry[h[IDX_W-1:0]];
                Alloc_Tag1 = entry[h[IDX_W-1:0]];
            end
        end
    end

    // Commit head advance, saturating at the post-grant speculative head
    always_comb begin
        h_adv       = h + (grant ? PTR_W'(n) : PTR_W'(0));
        cmt_illegal = (Cmt_Alloc == 2'd3);
        cmt         = cmt_illegal ? 2'd2 : Cmt_Alloc;
        cmt_over    = PTR_W'(cmt) > (h_adv - c);
        c_next      = cmt_over ? h_adv : (c + PTR_W'(cmt));
        h_next      = Flush ? c_next : h_adv;
    end

    // Releases land at the tail in port order; overfilling ones are dropped
    always_comb begin
        rel0_ok  = Rel_Valid[0] && ((t - c) < PTR_W'(DEPTH));
        t1       = t + PTR_W'(rel0_ok);
        rel1_ok  = Rel_Valid[1] && ((t1 - c) < PTR_W'(DEPTH));
        t_next   = t1 + PTR_W'(rel1_ok);
        rel_drop = (Rel_Valid[0] && !rel0_ok) || (Rel_Valid[1] && !rel1_ok);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry[i] <= TAG_W'(NUM_ARCH + i);
            end
            h     <= '0;
            c     <= '0;
            t     <= PTR_W'(DEPTH);
            err_q <= 1'b0;
        end else begin
            if (rel0_ok) entry[t[IDX_W-1:0]]  <= Rel_Tag0;
            if (rel1_ok) entry[t1[IDX_W-1:0]] <= Rel_Tag1;
            h     <= h_next;
            c     <= c_next;
            t     <= t_next;
            err_q <= err_q | cmt_illegal | cmt_over | rel_drop;
        end
    end

endmodule

// File: tb/tb_rename_free_list_ctrl.sv
// Directed bench for rename_free_list_ctrl: expected values are queued as
// stimulus is driven and checked against the DUT at the following falling edge.
module tb_rename_free_list_ctrl;

    logic       Clk;
    logic       Rst;
    logic       Flush;
    logic       Stall;
    logic [1:0] Alloc_Req;
    logic       Alloc_Grant;
    logic [5:0] Alloc_Tag0;
    logic [5:0] Alloc_Tag1;
    logic       Alloc_Stall;
    logic [1:0] Cmt_Alloc;
    logic [1:0] Rel_Valid;
    logic [5:0] Rel_Tag0;
    logic [5:0] Rel_Tag1;
    logic [5:0] Free_Cnt;
    logic       Err;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string name;
        int    value;
    } exp_t;

    exp_t sb[$];

    rename_free_list_ctrl dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Flush       (Flush),
        .Stall       (Stall),
        .Alloc_Req   (Alloc_Req),
        .Alloc_Grant (Alloc_Grant),
        .Alloc_Tag0  (Alloc_Tag0),
        .Alloc_Tag1  (Alloc_Tag1),
        .Alloc_Stall (Alloc_Stall),
        .Cmt_Alloc   (Cmt_Alloc),
        .Rel_Valid   (Rel_Valid),
        .Rel_Tag0    (Rel_Tag0),
        .Rel_Tag1    (Rel_Tag1),
        .Free_Cnt    (Free_Cnt),
        .Err         (Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic expect_val(input string name, input int value);
        exp_t e;
        e.name  = name;
        e.value = value;
        sb.push_back(e);
    endtask

    function automatic int observe(input string name);
        int v;
        v = -1;
        case (name)
            "grant": v = int'(Alloc_Grant);
            "stall": v = int'(Alloc_Stall);
            "tag0":  v = int'(Alloc_Tag0);
            "tag1":  v = int'(Alloc_Tag1);
            "free":  v = int'(Free_Cnt);
            "err":   v = int'(Err);
            default: v = -1;
        endcase
        return v;
    endfunction

    // Compare all queued expectations mid-cycle, then advance past the next edge
    task automatic tick();
        exp_t e;
        int   obs;
        @(negedge Clk);
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.name);
            compared++;
            assert (obs === e.value) else begin
                mismatched++;
                $error("FAIL %s: observed %0d expected %0d", e.name, obs, e.value);
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst       = 1'b1;
        Flush     = 1'b0;
        Stall     = 1'b0;
        Alloc_Req = 2'b00;
        Cmt_Alloc = 2'd0;
        Rel_Valid = 2'b00;
        tick();
        Rst = 1'b0;
    endtask

    initial begin
        Rst       = 1'b1;
        Flush     = 1'b0;
        Stall     = 1'b0;
        Alloc_Req = 2'b11;
        Cmt_Alloc = 2'd0;
        Rel_Valid = 2'b00;
        Rel_Tag0  = '0;
        Rel_Tag1  = '0;

        // Outputs held quiet in reset even with requests pending
        expect_val("grant", 0);
        expect_val("stall", 0);
        expect_val("tag0", 0);
        expect_val("tag1", 0);
        tick();
        tick();
        Rst       = 1'b0;
        Alloc_Req = 2'b00;
        expect_val("free", 32);
        expect_val("err", 0);
        tick();

        // Drain the whole list two at a time
        for (int i = 0; i < 16; i++) begin
            Alloc_Req = 2'b11;
            expect_val("grant", 1);
            expect_val("stall", 0);
            expect_val("tag0", 32 + 2 * i);
            expect_val("tag1", 33 + 2 * i);
            expect_val("free", 32 - 2 * i);
            tick();
        end
        expect_val("grant", 0);
        expect_val("stall", 1);
        expect_val("free", 0);
        expect_val("err", 0);
        tick();

        // Retire four allocations, then return one tag
        Alloc_Req = 2'b00;
        Cmt_Alloc = 2'd2;
        tick();
        tick();
        Cmt_Alloc = 2'd0;
        Rel_Valid = 2'b01;
        Rel_Tag0  = 6'd7;
        tick();
        Rel_Valid = 2'b00;

        // One free tag: double request stalls, single slot-1 request succeeds
        Alloc_Req = 2'b11;
        expect_val("grant", 0);
        expect_val("stall", 1);
        expect_val("free", 1);
        tick();
        Alloc_Req = 2'b10;
        expect_val("grant", 1);
        expect_val("stall", 0);
        expect_val("tag1", 7);
        expect_val("free", 1);
        tick();

        // Empty list: same-cycle releases are not bypassed
        Alloc_Req = 2'b11;
        Rel_Valid = 2'b11;
        Rel_Tag0  = 6'd5;
        Rel_Tag1  = 6'd9;
        expect_val("grant", 0);
        expect_val("stall", 1);
        expect_val("free", 0);
        tick();
        Rel_Valid = 2'b00;
        expect_val("grant", 1);
        expect_val("tag0", 5);
        expect_val("tag1", 9);
        expect_val("free", 2);
        expect_val("err", 0);
        tick();
        Alloc_Req = 2'b00;
        expect_val("free", 0);
        tick();

        // Allocate six, commit two, flush: head returns to tag 34
        do_reset();
        for (int i = 0; i < 3; i++) begin
            Alloc_Req = 2'b11;
            expect_val("tag0", 32 + 2 * i);
            expect_val("tag1", 33 + 2 * i);
            tick();
        end
        Alloc_Req = 2'b00;
        Cmt_Alloc = 2'd2;
        expect_val("free", 26);
        tick();
        Cmt_Alloc = 2'd0;
        Flush     = 1'b1;
        Alloc_Req = 2'b11;
        expect_val("grant", 0);
        expect_val("stall", 0);
        tick();
        Flush     = 1'b0;
        Alloc_Req = 2'b01;
        expect_val("free", 30);
        expect_val("grant", 1);
        expect_val("tag0", 34);
        tick();

        // Flush together with Stall and requests
        Flush     = 1'b1;
        Stall     = 1'b1;
        Alloc_Req = 2'b11;
        expect_val("grant", 0);
        expect_val("stall", 0);
        expect_val("free", 29);
        tick();
        Flush     = 1'b0;
        Stall     = 1'b0;
        Alloc_Req = 2'b01;
        expect_val("free", 30);
        expect_val("grant", 1);
        expect_val("tag0", 34);
        tick();

        // Stall alone blocks grant without a stall request
        Stall     = 1'b1;
        expect_val("grant", 0);
        expect_val("stall", 0);
        expect_val("free", 29);
        tick();
        Stall     = 1'b0;
        Alloc_Req = 2'b00;

        // Illegal commit count overruns one outstanding tag: saturates at head
        Cmt_Alloc = 2'd3;
        expect_val("err", 0);
        tick();
        Cmt_Alloc = 2'd0;
        Flush     = 1'b1;
        expect_val("err", 1);
        tick();
        Flush = 1'b0;
        expect_val("free", 29);
        tick();

        // Release into a full list is dropped and Err sticks until reset
        do_reset();
        Rel_Valid = 2'b01;
        Rel_Tag0  = 6'd3;
        expect_val("free", 32);
        expect_val("err", 0);
        tick();
        Rel_Valid = 2'b00;
        expect_val("err", 1);
        expect_val("free", 32);
        tick();
        tick();
        expect_val("err", 1);
        tick();
        do_reset();
        expect_val("err", 0);
        expect_val("free", 32);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
